// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 32-bit multi-cycle CPU front end.
//   - Instruction field positions (opcode, rd, rs, func, 15-bit immediate)
//   - HALT_OP: opcode that stops sequential fetch
//   - fetch_state_e: fetch-stage FSM encoding (explicit values kept stable
//     so older tooling and waveform decoders continue to match)
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 27;
   localparam int RD_MSB   = 26;
   localparam int RD_LSB   = 22;
   localparam int RS_MSB   = 21;
   localparam int RS_LSB   = 17;
   localparam int FUNC_MSB = 16;
   localparam int FUNC_LSB = 15;
   localparam int IMM_MSB  = 14;
   localparam int IMM_LSB  = 0;

   localparam logic [4:0] HALT_OP = 5'h1F;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_OUT  = 3'd2,
      S_DROP = 3'd3,
      S_HALT = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/instr_field_split.sv
// ---------------------------------------------------------------------------
// instr_field_split
// Purely combinational slicing of a 32-bit instruction word into its fields.
// Shared by fetch (registered output word) and decode.
// Ports:
//   instr  in  32  instruction word
//   opcode out 5   instr[31:27]
//   rd     out 5   instr[26:22]
//   rs     out 5   instr[21:17]
//   func   out 2   instr[16:15]
//   imm    out 15  instr[14:0], raw (unextended) immediate
// ---------------------------------------------------------------------------
module instr_field_split
   import cpu_pkg::*;
(
   input  logic [31:0]                instr,
   output logic [OPC_MSB-OPC_LSB:0]   opcode,
   output logic [RD_MSB-RD_LSB:0]     rd,
   output logic [RS_MSB-RS_LSB:0]     rs,
   output logic [FUNC_MSB-FUNC_LSB:0] func,
   output logic [IMM_MSB-IMM_LSB:0]   imm
);

   assign opcode = instr[OPC_MSB:OPC_LSB];
   assign rd     = instr[RD_MSB:RD_LSB];
   assign rs     = instr[RS_MSB:RS_LSB];
   assign func   = instr[FUNC_MSB:FUNC_LSB];
   assign imm    = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch for the 32-bit multi-cycle CPU. Owns the PC, issues one
// instruction-memory request at a time (req held until a one-cycle ack),
// registers the returned word and presents it to decode over valid/ready
// with the fields pre-split. Handles branch redirects and the HALT opcode.
//
// Optional build macro: FETCH_PREFETCH_EN adds a one-entry prefetch buffer
// so back-to-back instructions reach decode without a valid bubble.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req_o/addr_o     fetch request and address (addr stable while req)
//   imem_ack_i/rdata_i    one-cycle ack with instruction word
//   redirect_i/pc_i       taken branch/jump pulse and its target
//   id_valid_o/ready_i    handshake to decode
//   id_pc_o, id_instr_o   PC and raw word of the presented instruction
//   id_opcode_o .. imm_o  field slices of id_instr_o
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4,
   parameter logic [4:0]  HALT_OP  = cpu_pkg::HALT_OP
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_instr_o,
   output logic [4:0]  id_opcode_o,
   output logic [4:0]  id_rd_o,
   output logic [4:0]  id_rs_o,
   output logic [1:0]  id_func_o,
   output logic [14:0] id_imm_o
);
   import cpu_pkg::*;

   fetch_state_e state;
   // pc is always the address on the memory bus; while draining a stale
   // request (S_DROP) it keeps the old address and the target waits in redir_pc.
   logic [31:0]  pc;
   logic [31:0]  redir_pc;
   logic [31:0]  pc_inc;
   logic         vld_p1;
   logic [31:0]  pc_p1;
   logic [31:0]  instr_p1;
   logic         hs;

   assign pc_inc = pc + 32'(PC_STEP);
   assign hs     = vld_p1 && id_ready_i;

`ifdef FETCH_PREFETCH_EN
   logic         pf_vld;
   logic [31:0]  pf_instr;
   logic [31:0]  pf_pc;
   logic         pf_req;
   logic         pf_ack;

   // A HALT in the output stage must not pull in the following word.
   assign pf_req     = (state == S_OUT) && !pf_vld && (id_opcode_o != HALT_OP);
   assign pf_ack     = pf_req && imem_ack_i;
   assign imem_req_o = (state == S_REQ) || (state == S_DROP) || pf_req;
`else
   assign imem_req_o = (state == S_REQ) || (state == S_DROP);
`endif
   assign imem_addr_o = pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         redir_pc <= '0;
         vld_p1   <= 1'b0;
         pc_p1    <= '0;
         instr_p1 <= '0;
`ifdef FETCH_PREFETCH_EN
         pf_vld   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: state <= S_REQ;

            // ---- request stage -> output registers (p1) ----
            S_REQ: begin
               if (redirect_i) begin
                  redir_pc <= redirect_pc_i;
                  if (imem_ack_i) begin
                     pc    <= redirect_pc_i;
                     state <= S_REQ;
                  end else begin
                     state <= S_DROP;
                  end
               end else if (imem_ack_i) begin
                  instr_p1 <= imem_rdata_i;
                  pc_p1    <= pc;
                  vld_p1   <= 1'b1;
                  pc       <= pc_inc;
                  state    <= S_OUT;
               end
            end

            S_DROP: begin
               if (redirect_i) redir_pc <= redirect_pc_i;
               if (imem_ack_i) begin
                  pc    <= redirect_i ? redirect_pc_i : redir_pc;
                  state <= S_REQ;
               end
            end

`ifdef FETCH_PREFETCH_EN
            S_OUT: begin
               if (redirect_i) begin
                  vld_p1   <= 1'b0;
                  pf_vld   <= 1'b0;
                  redir_pc <= redirect_pc_i;
                  if (pf_req && !imem_ack_i) begin
                     state <= S_DROP;
                  end else begin
                     pc    <= redirect_pc_i;
                     state <= S_REQ;
                  end
               end else begin
                  if (pf_ack) pc <= pc_inc;
                  if (hs) begin
                     if (pf_vld) begin
                        instr_p1 <= pf_instr;
                        pc_p1    <= pf_pc;
                        pf_vld   <= 1'b0;
                     end else if (pf_ack) begin
                        instr_p1 <= imem_rdata_i;
                        pc_p1    <= pc;
                     end else begin
                        // An outstanding prefetch simply continues in S_REQ.
                        vld_p1 <= 1'b0;
                        state  <= (id_opcode_o == HALT_OP) ? S_HALT : S_REQ;
                     end
                  end else if (pf_ack) begin
                     pf_vld   <= 1'b1;
                     pf_instr <= imem_rdata_i;
                     pf_pc    <= pc;
                  end
               end
            end
`else
            S_OUT: begin
               if (redirect_i) begin
                  vld_p1 <= 1'b0;
                  pc     <= redirect_pc_i;
                  state  <= S_REQ;
               end else if (hs) begin
                  vld_p1 <= 1'b0;
                  state  <= (id_opcode_o == HALT_OP) ? S_HALT : S_REQ;
               end
            end
`endif

            S_HALT: begin
               if (redirect_i) begin
                  pc    <= redirect_pc_i;
                  state <= S_REQ;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign id_valid_o = vld_p1;
   assign id_pc_o    = pc_p1;
   assign id_instr_o = instr_p1;

   instr_field_split u_split (
      .instr  (instr_p1),
      .opcode (id_opcode_o),
      .rd     (id_rd_o),
      .rs     (id_rs_o),
      .func   (id_func_o),
      .imm    (id_imm_o)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed testbench for fetch_stage: reset, basic fetch and field split,
// decode backpressure, redirect against ack, draining a stale request, HALT,
// reset during a request, PC wrap, and (with FETCH_PREFETCH_EN) bubble-free
// back-to-back delivery.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [4:0]  id_opcode;
   logic [4:0]  id_rd;
   logic [4:0]  id_rs;
   logic [1:0]  id_func;
   logic [14:0] id_imm;

   logic        ack_drv = 1'b0;
   logic [31:0] rdata_drv = '0;
   logic        auto_ack = 1'b0;

   // auto_ack models a zero-wait memory returning its own address as data.
   assign imem_ack   = auto_ack ? imem_req  : ack_drv;
   assign imem_rdata = auto_ack ? imem_addr : rdata_drv;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ack_i    (imem_ack),
      .imem_rdata_i  (imem_rdata),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .id_valid_o    (id_valid),
      .id_ready_i    (id_ready),
      .id_pc_o       (id_pc),
      .id_instr_o    (id_instr),
      .id_opcode_o   (id_opcode),
      .id_rd_o       (id_rd),
      .id_rs_o       (id_rs),
      .id_func_o     (id_func),
      .id_imm_o      (id_imm)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int quiet_hits;

      // ---- reset ----
      tick(); tick();
      check("rst_req",    32'(imem_req),  32'd0);
      check("rst_valid",  32'(id_valid),  32'd0);
      check("rst_pc",     id_pc,          32'd0);
      check("rst_instr",  id_instr,       32'd0);
      check("rst_opcode", 32'(id_opcode), 32'd0);

      rst_n = 1'b1;
      tick();
      check("first_req",  32'(imem_req), 32'd1);
      check("first_addr", imem_addr,     32'h0);

      // ---- basic fetch, ack two cycles into the request ----
      tick();
      check("req_held", 32'(imem_req), 32'd1);
      ack_drv = 1'b1; rdata_drv = 32'h0844_7FFF;
      tick();
      ack_drv = 1'b0; rdata_drv = '0;
      check("f1_valid",  32'(id_valid),  32'd1);
      check("f1_pc",     id_pc,          32'h0);
      check("f1_instr",  id_instr,       32'h0844_7FFF);
      check("f1_opcode", 32'(id_opcode), 32'd1);
      check("f1_rd",     32'(id_rd),     32'd1);
      check("f1_rs",     32'(id_rs),     32'd2);
      check("f1_func",   32'(id_func),   32'd0);
      check("f1_imm",    32'(id_imm),    32'h7FFF);
      check("f1_noreq",  32'(imem_req),  32'd0);

      // ---- decode backpressure ----
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", 32'(id_valid), 32'd1);
         check("hold_instr", id_instr,      32'h0844_7FFF);
         check("hold_pc",    id_pc,         32'h0);
         check("hold_noreq", 32'(imem_req), 32'd0);
      end
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      check("hs_valid", 32'(id_valid), 32'd0);
      check("hs_req",   32'(imem_req), 32'd1);
      check("hs_addr",  imem_addr,     32'h4);

      // ---- redirect in the same cycle as an ack ----
      ack_drv = 1'b1; rdata_drv = 32'hDEAD_BEEF;
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      ack_drv = 1'b0; redirect = 1'b0;
      check("rda_valid", 32'(id_valid), 32'd0);
      check("rda_req",   32'(imem_req), 32'd1);
      check("rda_addr",  imem_addr,     32'h100);
      check("rda_instr", id_instr,      32'h0844_7FFF);
      tick();
      check("rda_valid2", 32'(id_valid), 32'd0);

      // fetch at the redirect target, then consume it
      ack_drv = 1'b1; rdata_drv = 32'h1000_0003;
      tick();
      ack_drv = 1'b0;
      check("f2_valid", 32'(id_valid), 32'd1);
      check("f2_pc",    id_pc,         32'h100);
      check("f2_instr", id_instr,      32'h1000_0003);
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      check("f2_next_addr", imem_addr, 32'h104);

      // ---- redirect with a request outstanding, ack three cycles later ----
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      check("drop_req",  32'(imem_req), 32'd1);
      check("drop_addr", imem_addr,     32'h104);
      tick(); tick();
      check("drop_addr2",  imem_addr,     32'h104);
      check("drop_valid",  32'(id_valid), 32'd0);
      ack_drv = 1'b1; rdata_drv = 32'hBADB_AD00;
      tick();
      ack_drv = 1'b0;
      check("drop_done_valid", 32'(id_valid), 32'd0);
      check("drop_done_req",   32'(imem_req), 32'd1);
      check("drop_done_addr",  imem_addr,     32'h100);

      // ---- HALT ----
      ack_drv = 1'b1; rdata_drv = 32'hF800_0000; id_ready = 1'b1;
      tick();
      ack_drv = 1'b0;
      check("halt_valid",  32'(id_valid),  32'd1);
      check("halt_opcode", 32'(id_opcode), 32'h1F);
      check("halt_pc",     id_pc,          32'h100);
      tick();
      id_ready = 1'b0;
      check("halt_hs_valid", 32'(id_valid), 32'd0);
      check("halt_hs_req",   32'(imem_req), 32'd0);
      quiet_hits = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (imem_req || id_valid) quiet_hits++;
      end
      check("halt_quiet", 32'(quiet_hits), 32'd0);
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      check("resume_req",  32'(imem_req), 32'd1);
      check("resume_addr", imem_addr,     32'h40);

      // ---- reset during a request, with an ack arriving under reset ----
      rst_n = 1'b0;
      tick();
      check("mrst_req", 32'(imem_req), 32'd0);
      ack_drv = 1'b1; rdata_drv = 32'h1234_5678;
      tick();
      ack_drv = 1'b0;
      check("mrst_valid", 32'(id_valid), 32'd0);
      check("mrst_instr", id_instr,      32'd0);
      rst_n = 1'b1;
      tick();
      check("mrst_first_req",   32'(imem_req), 32'd1);
      check("mrst_first_addr",  imem_addr,     32'h0);
      check("mrst_first_valid", 32'(id_valid), 32'd0);

      // ---- redirect beats handshake in S_OUT, then PC wrap ----
      ack_drv = 1'b1; rdata_drv = 32'h0000_0000;
      tick();
      ack_drv = 1'b0;
      check("w_valid", 32'(id_valid), 32'd1);
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; id_ready = 1'b1;
      tick();
      redirect = 1'b0; id_ready = 1'b0;
      check("w_redir_valid", 32'(id_valid), 32'd0);
      check("w_redir_addr",  imem_addr,     32'hFFFF_FFFC);
      ack_drv = 1'b1; rdata_drv = 32'h0000_1234;
      tick();
      ack_drv = 1'b0;
      check("w_pc",  id_pc,          32'hFFFF_FFFC);
      check("w_imm", 32'(id_imm),    32'h1234);
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      check("w_wrap_req",  32'(imem_req), 32'd1);
      check("w_wrap_addr", imem_addr,     32'h0);

`ifdef FETCH_PREFETCH_EN
      // ---- prefetch: zero-wait memory, decode always ready ----
      auto_ack = 1'b1; id_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("pf_valid", 32'(id_valid), 32'd1);
         check("pf_pc",    id_pc,         32'(i * 4));
      end
      redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect = 1'b0; auto_ack = 1'b0; id_ready = 1'b0;
      check("pf_redir_valid", 32'(id_valid), 32'd0);
      check("pf_redir_addr",  imem_addr,     32'h200);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
